replay_sample_fifo: RTL and testbench
=====================================

Name: replay_sample_fifo

Overview:
Parametrised successor to the team's sample FIFO. It buffers feature samples for the tree-evaluation engines. A sample set is pushed once and can be replayed many times: the consumer marks a read position and later rewinds to it, and marked entries are protected from overwrite. It adds occupancy and almost-full reporting, overflow/underflow flags and a hold/stream mode.

Parameters:
DATA_W, 16, sample word width in bits
DEPTH, 32, number of entries; must be a power of 2, minimum 4
ADDR_W, $clog2(DEPTH), index width (derived; do not override)
AFULL_TH, DEPTH-4, retained-entry count at or above which o_almost_full asserts

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
i_flush  in  1  empty the FIFO; all pointers go to 0
i_hold  in  1  1 = replay mode (mark frozen); 0 = stream mode (mark tracks read pointer)
i_mark  in  1  capture current read pointer as the rewind point (effective only when i_hold=1)
i_rewind  in  1  restore read pointer to the mark
i_push  in  1  write request
i_rear  in  DATA_W  write data
i_pop  in  1  read request
o_front  out  DATA_W  read data, registered
o_vld  out  1  o_front is valid this cycle
o_full  out  1  retained == DEPTH
o_almost_full  out  1  retained >= AFULL_TH
o_empty  out  1  readable == 0
o_count  out  ADDR_W+1  readable entries (wptr - rptr)
o_ovf  out  1  one-cycle pulse: push rejected
o_udf  out  1  one-cycle pulse: pop rejected
o_rptr  out  ADDR_W+1  read pointer, debug
o_wptr  out  ADDR_W+1  write pointer, debug

Behaviour:
- Pointers: wptr, rptr and mptr (mark) are ADDR_W+1 bits. The RAM index is ptr[ADDR_W-1:0]. The MSB is the wrap bit; all arithmetic is modulo 2^(ADDR_W+1).
- Derived counts: readable = wptr - rptr; retained = wptr - mptr. Invariant: mptr <= rptr <= wptr (in modulo order), and retained <= DEPTH.
- Reset (rst=1): all pointers 0, o_front 0, o_vld 0, o_ovf 0, o_udf 0. Consequently o_empty=1, o_full=0, o_almost_full=0, o_count=0.
- Per-cycle priority: rst > i_flush > i_rewind > i_mark > i_pop. i_push is evaluated independently, except when a flush is taking effect.
- Flush: wptr, rptr and mptr all go to 0 and o_vld=0. A push in the same cycle is dropped without an o_ovf pulse.
- Push: accepted iff o_full=0, judged on the state before the edge. On accept, RAM[wptr] <= i_rear and wptr+1. If full, the push is dropped and o_ovf=1 on the next cycle. There is no bypass when a pop frees space in the same cycle.
- Pop: accepted iff o_empty=0 (pre-edge state) and there is no rewind in the same cycle. On accept, o_front <= RAM[rptr], rptr+1 and o_vld=1 on the next cycle (latency 1). Otherwise o_vld=0.
  - A pop while empty is ignored and o_udf=1 on the next cycle.
  - A push into an empty FIFO plus a pop in the same cycle: the pop is rejected (no fall-through) and o_udf pulses.
- Rewind: rptr <= mptr. A pop in the same cycle is ignored, with no o_udf. o_vld=0 next cycle. If rewind and mark are asserted together, rewind wins and the mark is ignored.
- Mark and mode:
  - i_hold=0 (stream): mptr <= next rptr every cycle, so popped entries are freed immediately and i_mark is ignored.
  - i_hold=1 (replay): mptr is frozen. i_mark sets mptr <= current (pre-pop) rptr.
  - Transition from hold 1 to 0: mptr catches up to rptr on the next edge.
- Full is based on retained, not readable. In replay mode the FIFO can report full while o_count < DEPTH.
- o_front holds its last value when o_vld=0.
- Status outputs are combinational from the registered pointers.

Test Plan:
1. Reset, then push 10..29 (20 words, DEPTH=32), then pop 20 times -> o_vld pulses carry 10..29 in order, 1-cycle latency; o_count 20->0; o_empty=1 at the end; o_udf never asserted.
2. Push 0..31, then push 99 -> o_full=1 after the 32nd push; 99 dropped; o_ovf pulses once; o_almost_full asserted from count 28; wptr=32 (wrap bit set).
3. i_hold=1: push 0..9, pop 3, mark (mptr=3), pop 4 (values 3..6), rewind, pop 7 -> values 3..9; o_count=0; rptr=10.
4. i_hold=1: mark at rptr=0, push 32 words, pop all 32, push 1 more -> o_full stays 1 and the push is dropped with o_ovf. Then i_hold=0 for one cycle -> o_full=0 and the next push is accepted.
5. Simultaneous events:
   - Empty FIFO, push 5 and pop in the same cycle -> pop rejected, o_udf=1; next-cycle pop returns 5.
   - Rewind and pop in the same cycle -> o_vld=0, rptr=mptr.
6. Mid-operation flush and reset:
   - After 12 pushes and 4 pops, flush together with a push of 77 -> pointers 0, o_empty=1, 77 not stored, no o_ovf.
   - Then push 1, 2 and assert rst during a pop -> o_vld=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/replay_sample_fifo.sv
// Sample FIFO with mark/rewind replay for the tree-evaluation engines.
// Entries at or after the mark are protected; stream mode frees them as they are read.
module replay_sample_fifo #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int AFULL_TH = DEPTH - 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_hold,
  input  logic              i_mark,
  input  logic              i_rewind,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_rear,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_front,
  output logic              o_vld,
  output logic              o_full,
  output logic              o_almost_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_ovf,
  output logic              o_udf,
  output logic [ADDR_W:0]   o_rptr,
  output logic [ADDR_W:0]   o_wptr
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]   mptr_q, mptr_d;
  logic [DATA_W-1:0] front_q, front_d;
  logic              vld_q, vld_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic [ADDR_W:0]   readable;
  logic [ADDR_W:0]   retained;
  logic              full;
  logic              empty;
  logic              push_ok;
  logic              pop_ok;

  assign readable = wptr_q - rptr_q;
  assign retained = wptr_q - mptr_q;
  assign full     = (retained == DEPTH_C);
  assign empty    = (readable == '0);

  // Push is judged purely on pre-edge fullness; a same-cycle pop never makes room.
  assign push_ok  = i_push && !full && !i_flush;
  assign pop_ok   = i_pop && !empty && !i_flush && !i_rewind;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    mptr_d  = mptr_q;
    front_d = front_q;
    vld_d   = 1'b0;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    if (i_flush) begin
      wptr_d = '0;
      rptr_d = '0;
      mptr_d = '0;
    end else begin
      ovf_d = i_push && full;
      if (push_ok) wptr_d = wptr_q + ONE_C;
      if (i_rewind) begin
        rptr_d = mptr_q;
      end else begin
        udf_d = i_pop && empty;
        if (pop_ok) begin
          rptr_d  = rptr_q + ONE_C;
          front_d = mem[rptr_q[ADDR_W-1:0]];
          vld_d   = 1'b1;
        end
      end
      // Replay mode freezes the mark; stream mode drags it along with the reader.
      if (!i_hold)                   mptr_d = rptr_d;
      else if (i_mark && !i_rewind)  mptr_d = rptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q[ADDR_W-1:0]] <= i_rear;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      mptr_q  <= '0;
      front_q <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      mptr_q  <= mptr_d;
      front_q <= front_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign o_front       = front_q;
  assign o_vld         = vld_q;
  assign o_full        = full;
  assign o_almost_full = (retained >= AFULL_C);
  assign o_empty       = empty;
  assign o_count       = readable;
  assign o_ovf         = ovf_q;
  assign o_udf         = udf_q;
  assign o_rptr        = rptr_q;
  assign o_wptr        = wptr_q;

endmodule

// File: tb/tb_replay_sample_fifo.sv
// Scoreboard bench for replay_sample_fifo: expected pop data is queued by the stimulus
// and a negedge monitor pops and compares whenever o_vld is high.
module tb_replay_sample_fifo;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst, i_flush, i_hold, i_mark, i_rewind, i_push, i_pop;
  logic [DATA_W-1:0] i_rear;
  logic [DATA_W-1:0] o_front;
  logic              o_vld, o_full, o_almost_full, o_empty, o_ovf, o_udf;
  logic [ADDR_W:0]   o_count, o_rptr, o_wptr;

  int checks = 0;
  int errors = 0;
  int ovf_seen = 0;
  int udf_seen = 0;
  logic [DATA_W-1:0] exp_q[$];

  replay_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_hold(i_hold), .i_mark(i_mark),
    .i_rewind(i_rewind), .i_push(i_push), .i_rear(i_rear), .i_pop(i_pop),
    .o_front(o_front), .o_vld(o_vld), .o_full(o_full), .o_almost_full(o_almost_full),
    .o_empty(o_empty), .o_count(o_count), .o_ovf(o_ovf), .o_udf(o_udf),
    .o_rptr(o_rptr), .o_wptr(o_wptr)
  );

  always #5 clk = ~clk;

  // Monitor: data checks and pulse counting, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_ovf) ovf_seen++;
      if (o_udf) udf_seen++;
      if (o_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_vld got front=%0d, required no valid output", o_front);
        end else begin
          logic [DATA_W-1:0] e;
          e = exp_q.pop_front();
          if (o_front !== e) begin
            errors++;
            $display("FAIL pop_data got %0d required %0d", o_front, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    i_push = 1'b1; i_rear = DATA_W'(v);
    tick();
    i_push = 1'b0;
  endtask

  task automatic pop(input int v);
    exp_q.push_back(DATA_W'(v));
    i_pop = 1'b1;
    tick();
    i_pop = 1'b0;
  endtask

  task automatic flush();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
  endtask

  initial begin
    int u0, o0;
    rst = 1'b1; i_flush = 0; i_hold = 0; i_mark = 0; i_rewind = 0;
    i_push = 0; i_pop = 0; i_rear = '0;
    tick(); tick();
    chk("rst_empty", int'(o_empty), 1);
    chk("rst_full", int'(o_full), 0);
    chk("rst_count", int'(o_count), 0);
    chk("rst_vld", int'(o_vld), 0);
    rst = 1'b0;

    // 1: basic stream
    for (int i = 10; i < 30; i++) push(i);
    chk("t1_count20", int'(o_count), 20);
    for (int i = 10; i < 30; i++) pop(i);
    tick();
    chk("t1_count0", int'(o_count), 0);
    chk("t1_empty", int'(o_empty), 1);
    chk("t1_no_udf", udf_seen, 0);

    // 2: fill, almost-full threshold, overflow
    flush();
    for (int i = 0; i < 32; i++) begin
      push(i);
      if (i == 26) chk("t2_af_27", int'(o_almost_full), 0);
      if (i == 27) chk("t2_af_28", int'(o_almost_full), 1);
    end
    chk("t2_full", int'(o_full), 1);
    chk("t2_wptr", int'(o_wptr), 32);
    o0 = ovf_seen;
    push(99);
    chk("t2_ovf_pulse", int'(o_ovf), 1);
    tick();
    chk("t2_ovf_clear", int'(o_ovf), 0);
    chk("t2_ovf_once", ovf_seen - o0, 1);
    chk("t2_wptr_after", int'(o_wptr), 32);
    for (int i = 0; i < 32; i++) pop(i);
    chk("t2_empty", int'(o_empty), 1);

    // 3: mark and rewind
    flush();
    i_hold = 1'b1;
    for (int i = 0; i < 10; i++) push(i);
    for (int i = 0; i < 3; i++) pop(i);
    i_mark = 1'b1; tick(); i_mark = 1'b0;
    for (int i = 3; i < 7; i++) pop(i);
    i_rewind = 1'b1; tick(); i_rewind = 1'b0;
    chk("t3_rptr_rewind", int'(o_rptr), 3);
    for (int i = 3; i < 10; i++) pop(i);
    chk("t3_count", int'(o_count), 0);
    chk("t3_rptr", int'(o_rptr), 10);

    // 4: full on retained while nothing is readable
    flush();
    i_mark = 1'b1; tick(); i_mark = 1'b0;
    for (int i = 0; i < 32; i++) push(100 + i);
    for (int i = 0; i < 32; i++) pop(100 + i);
    chk("t4_count0", int'(o_count), 0);
    chk("t4_full_held", int'(o_full), 1);
    push(200);
    chk("t4_ovf", int'(o_ovf), 1);
    chk("t4_wptr", int'(o_wptr), 32);
    i_hold = 1'b0; tick();
    chk("t4_full_release", int'(o_full), 0);
    push(55);
    chk("t4_wptr_after", int'(o_wptr), 33);
    pop(55);

    // 5: simultaneous events
    flush();
    u0 = udf_seen;
    i_push = 1'b1; i_rear = 16'd5; i_pop = 1'b1;
    tick();
    i_push = 1'b0; i_pop = 1'b0;
    chk("t5_udf", int'(o_udf), 1);
    chk("t5_no_vld", int'(o_vld), 0);
    pop(5);
    push(8); push(9);
    i_hold = 1'b1;
    tick();
    pop(8);
    u0 = udf_seen;
    i_rewind = 1'b1; i_pop = 1'b1;
    tick();
    i_rewind = 1'b0; i_pop = 1'b0;
    chk("t5_rew_vld", int'(o_vld), 0);
    chk("t5_rew_rptr", int'(o_rptr), 1);
    chk("t5_rew_no_udf", int'(o_udf), 0);
    pop(8); pop(9);
    i_hold = 1'b0;

    // 6: flush with push, then reset during pop
    flush();
    for (int i = 0; i < 12; i++) push(i);
    for (int i = 0; i < 4; i++) pop(i);
    o0 = ovf_seen;
    i_flush = 1'b1; i_push = 1'b1; i_rear = 16'd77;
    tick();
    i_flush = 1'b0; i_push = 1'b0;
    chk("t6_wptr", int'(o_wptr), 0);
    chk("t6_rptr", int'(o_rptr), 0);
    chk("t6_empty", int'(o_empty), 1);
    chk("t6_no_ovf", int'(o_ovf), 0);
    push(1); push(2);
    rst = 1'b1; i_pop = 1'b1;
    tick();
    i_pop = 1'b0;
    chk("t6_rst_vld", int'(o_vld), 0);
    chk("t6_rst_front", int'(o_front), 0);
    chk("t6_rst_count", int'(o_count), 0);
    chk("t6_rst_empty", int'(o_empty), 1);
    chk("t6_rst_af", int'(o_almost_full), 0);
    chk("t6_rst_flags", int'({o_ovf, o_udf}), 0);
    chk("t6_rst_wptr", int'(o_wptr), 0);
    rst = 1'b0;

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
